// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-back, write-allocate L1 data cache.
// 8 sets of 16-byte lines, 16-bit byte address, 128-bit line-granular
// physical-memory side. mem_resp and the pmem_* strobes decode directly
// from the state register, so there is no combinational path from the
// request inputs to any output.
module l1_dcache (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_next_s;

  logic [7:0]     valid_r;
  logic [7:0]     dirty_r;
  logic [8:0]     tag_r  [0:7];
  logic [127:0]   data_r [0:7];

  logic [8:0]     addr_tag_s;
  logic [2:0]     index_s;
  logic [2:0]     word_s;
  logic [6:0]     word_lsb_s;
  logic [127:0]   line_s;
  logic [15:0]    hit_word_s;
  logic           hit_s;
  logic           is_req_s;
  logic           is_write_s;
  logic           read_hit_s;
  logic           write_hit_s;
  logic           fill_done_s;
  logic           wb_done_s;
  logic           unused_s;

  // Byte-lane merge of a CPU write into an existing 16-bit word.
  function automatic logic [15:0] merge_bytes(input logic [15:0] old_word,
                                              input logic [15:0] new_word,
                                              input logic [1:0]  be);
    merge_bytes = {(be[1] ? new_word[15:8] : old_word[15:8]),
                   (be[0] ? new_word[7:0]  : old_word[7:0])};
  endfunction

  assign addr_tag_s  = mem_address[15:7];
  assign index_s     = mem_address[6:4];
  assign word_s      = mem_address[3:1];
  assign word_lsb_s  = {word_s, 4'b0000};
  assign unused_s    = mem_address[0];
  assign line_s      = data_r[index_s];
  assign hit_word_s  = line_s[word_lsb_s +: 16];
  assign hit_s       = valid_r[index_s] && (tag_r[index_s] == addr_tag_s);
  assign is_req_s    = mem_read || mem_write;
  // A simultaneous read and write is serviced as a write.
  assign is_write_s  = mem_write;
  assign read_hit_s  = (state_r == IDLE) && is_req_s && !is_write_s && hit_s;
  assign write_hit_s = (state_r == IDLE) && is_write_s && hit_s;
  assign fill_done_s = (state_r == ALLOCATE) && pmem_resp;
  assign wb_done_s   = (state_r == WRITEBACK) && pmem_resp;

  // State register; reset abandons any in-flight fill or writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!is_req_s) begin
          state_next_s = IDLE;
        end else if (hit_s) begin
          state_next_s = RESP;
        end else if (valid_r[index_s] && dirty_r[index_s]) begin
          state_next_s = WRITEBACK;
        end else begin
          state_next_s = ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (pmem_resp) begin
          state_next_s = ALLOCATE;
        end else begin
          state_next_s = WRITEBACK;
        end
      end
      ALLOCATE: begin
        if (pmem_resp) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = ALLOCATE;
        end
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode from the state register only.
  always_comb begin
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0000;
    pmem_wdata   = line_s;
    case (state_r)
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_r[index_s], index_s, 4'b0000};
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[15:4], 4'b0000};
      end
      RESP:    mem_resp = 1'b1;
      IDLE:    mem_resp = 1'b0;
      default: mem_resp = 1'b0;
    endcase
  end

  // Read data register, loaded on a read hit and held through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rdata <= 16'h0000;
    end else if (read_hit_s) begin
      mem_rdata <= hit_word_s;
    end else begin
      mem_rdata <= mem_rdata;
    end
  end

  // Valid and dirty bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 8'h00;
      dirty_r <= 8'h00;
    end else if (fill_done_s) begin
      valid_r[index_s] <= 1'b1;
      dirty_r[index_s] <= 1'b0;
    end else if (wb_done_s) begin
      dirty_r[index_s] <= 1'b0;
    end else if (write_hit_s) begin
      dirty_r[index_s] <= 1'b1;
    end else begin
      dirty_r <= dirty_r;
    end
  end

  // Tag and data arrays; contents are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (fill_done_s) begin
      data_r[index_s] <= pmem_rdata;
      tag_r[index_s]  <= addr_tag_s;
    end else if (write_hit_s) begin
      data_r[index_s][word_lsb_s +: 16] <= merge_bytes(hit_word_s, mem_wdata, mem_byte_enable);
    end
  end

endmodule

// File: tb/tb_l1_dcache.sv
// Directed self-checking bench for l1_dcache with a 5-cycle latency
// physical-memory responder backed by a line-array model.
module tb_l1_dcache;

  logic         clk;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         rd_req;
  logic         iside;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  logic [127:0] mem_model [0:4095];
  int           n_chk;
  int           n_pass;
  int           cyc;
  int           wait_cnt;
  int           fill_cnt;
  int           wb_cnt;
  int           pw_cycles;
  int           both_cnt;
  int           fill_cyc;
  int           wb_cyc;
  logic [15:0]  fill_addr;
  logic [15:0]  wb_addr;
  logic [127:0] wb_data;

  // I-side style: the read request is the inverse of the response.
  assign mem_read = iside ? ~mem_resp : rd_req;

  l1_dcache dut (
    .clk(clk), .reset(reset), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_address(pmem_address),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Physical memory responder: answers after 5 cycles of a held request.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = 128'h0;
    wait_cnt = 0; cyc = 0; fill_cnt = 0; wb_cnt = 0; pw_cycles = 0; both_cnt = 0;
    fill_cyc = 0; wb_cyc = 0; fill_addr = 16'h0; wb_addr = 16'h0; wb_data = 128'h0;
    for (int i = 0; i < 4096; i++) begin
      for (int w = 0; w < 8; w++) begin
        mem_model[i][w*16 +: 16] = {i[11:0], w[2:0], 1'b1};
      end
    end
    mem_model[12'h123][47:32] = 16'hBEEF;
    forever begin
      @(negedge clk);
      cyc++;
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) both_cnt++;
      if (pmem_write) pw_cycles++;
      if (reset || !(pmem_read || pmem_write)) begin
        wait_cnt = 0;
      end else begin
        wait_cnt++;
        if (wait_cnt == 5) begin
          wait_cnt = 0;
          pmem_resp = 1'b1;
          if (pmem_write) begin
            mem_model[pmem_address[15:4]] = pmem_wdata;
            wb_cnt++; wb_addr = pmem_address; wb_data = pmem_wdata; wb_cyc = cyc;
          end else begin
            pmem_rdata = mem_model[pmem_address[15:4]];
            fill_cnt++; fill_addr = pmem_address; fill_cyc = cyc;
          end
        end
      end
    end
  end

  // One CPU request; n counts cycles from request to the mem_resp cycle.
  task automatic do_req(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                        input logic [1:0] be, output logic [15:0] rd, output int n,
                        output logic to);
    @(negedge clk);
    mem_address = a; mem_wdata = wd; mem_byte_enable = be;
    mem_write = wr; rd_req = ~wr;
    n = 0; to = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      if (mem_resp) break;
      if (n > 300) begin
        to = 1'b1;
        break;
      end
    end
    rd = mem_rdata;
    mem_write = 1'b0; rd_req = 1'b0;
  endtask

  logic [15:0] rd;
  logic        to;
  logic [5:0]  pat;
  int          n, f0, w0, p0, words, nc;

  // Directed stimulus.
  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b1; iside = 1'b0; rd_req = 1'b0; mem_write = 1'b0;
    mem_address = 16'h0; mem_byte_enable = 2'b00; mem_wdata = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_resp", mem_resp, 1'b0);
    chk("rst_rdata", mem_rdata, 16'h0000);
    chk("rst_pread", pmem_read, 1'b0);
    chk("rst_pwrite", pmem_write, 1'b0);
    chk("rst_paddr", pmem_address, 16'h0000);
    reset = 1'b0;

    // Cold read miss.
    f0 = fill_cnt; w0 = wb_cnt;
    do_req(1'b0, 16'h1234, 16'h0, 2'b00, rd, n, to);
    chk("cold_to", to, 1'b0);
    chk("cold_data", rd, 16'hBEEF);
    chk("cold_lat", n, 7);
    chk("cold_fills", fill_cnt - f0, 1);
    chk("cold_faddr", fill_addr, 16'h1230);
    chk("cold_wb", wb_cnt - w0, 0);

    // Read hit, then a held read request.
    f0 = fill_cnt;
    do_req(1'b0, 16'h1234, 16'h0, 2'b00, rd, n, to);
    chk("hit_data", rd, 16'hBEEF);
    chk("hit_lat", n, 1);
    @(negedge clk);
    mem_address = 16'h1234; rd_req = 1'b1; pat = 6'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = mem_resp;
    end
    rd_req = 1'b0;
    chk("hold_pattern", pat, 6'b010101);
    chk("hold_data", mem_rdata, 16'hBEEF);
    chk("hit_fills", fill_cnt - f0, 0);

    // Byte-masked write hit.
    p0 = pw_cycles;
    do_req(1'b1, 16'h1234, 16'hAA55, 2'b10, rd, n, to);
    chk("bw_lat", n, 1);
    chk("bw_no_pwrite", pw_cycles - p0, 0);
    do_req(1'b0, 16'h1234, 16'h0, 2'b00, rd, n, to);
    chk("bw_read", rd, 16'hAAEF);

    // Dirty conflict miss.
    f0 = fill_cnt; w0 = wb_cnt;
    do_req(1'b0, 16'h1A34, 16'h0, 2'b00, rd, n, to);
    chk("dm_to", to, 1'b0);
    chk("dm_data", rd, 16'h1A35);
    chk("dm_lat", n, 12);
    chk("dm_wbs", wb_cnt - w0, 1);
    chk("dm_wbaddr", wb_addr, 16'h1230);
    chk("dm_wbword", wb_data[47:32], 16'hAAEF);
    chk("dm_faddr", fill_addr, 16'h1A30);
    chk("dm_order", fill_cyc > wb_cyc, 1'b1);

    // Re-read of the evicted line: clean miss.
    f0 = fill_cnt; w0 = wb_cnt;
    do_req(1'b0, 16'h1234, 16'h0, 2'b00, rd, n, to);
    chk("rr_data", rd, 16'hAAEF);
    chk("rr_lat", n, 7);
    chk("rr_wbs", wb_cnt - w0, 0);
    chk("rr_fills", fill_cnt - f0, 1);

    // Reset during ALLOCATE.
    f0 = fill_cnt;
    @(negedge clk);
    mem_address = 16'h5678; rd_req = 1'b1; nc = 0;
    while (!pmem_read && nc < 20) begin
      @(negedge clk);
      nc++;
    end
    chk("ra_pread_seen", pmem_read, 1'b1);
    @(negedge clk);
    reset = 1'b1; rd_req = 1'b0;
    #1;
    chk("ra_pread_drop", pmem_read, 1'b0);
    chk("ra_resp", mem_resp, 1'b0);
    repeat (2) @(negedge clk);
    chk("ra_resp_hold", mem_resp, 1'b0);
    reset = 1'b0;
    chk("ra_no_fill", fill_cnt - f0, 0);
    do_req(1'b0, 16'h5678, 16'h0, 2'b00, rd, n, to);
    chk("ra_remiss_lat", n, 7);
    chk("ra_remiss_data", rd, 16'h5679);
    chk("ra_remiss_fills", fill_cnt - f0, 1);

    // I-side style sequential fetch.
    f0 = fill_cnt; w0 = wb_cnt;
    @(negedge clk);
    mem_address = 16'h0000; iside = 1'b1; words = 0; nc = 0;
    while (words < 16 && nc < 500) begin
      @(negedge clk);
      nc++;
      if (mem_resp) begin
        chk("iside_word", mem_rdata, mem_address | 16'h0001);
        words++;
        if (words == 16) iside = 1'b0;
        else mem_address = mem_address + 16'h0002;
      end
    end
    iside = 1'b0;
    chk("iside_done", words, 16);
    chk("iside_fills", fill_cnt - f0, 2);
    chk("iside_wbs", wb_cnt - w0, 0);

    // Write hit with no byte lanes still dirties the line.
    do_req(1'b1, 16'h0004, 16'hFFFF, 2'b00, rd, n, to);
    chk("be0_lat", n, 1);
    do_req(1'b0, 16'h0004, 16'h0, 2'b00, rd, n, to);
    chk("be0_data", rd, 16'h0005);
    w0 = wb_cnt;
    do_req(1'b0, 16'h0084, 16'h0, 2'b00, rd, n, to);
    chk("be0_evict_wbs", wb_cnt - w0, 1);
    chk("be0_wbaddr", wb_addr, 16'h0000);
    chk("be0_wbword", wb_data[47:32], 16'h0005);
    chk("be0_lat_miss", n, 12);
    chk("be0_newdata", rd, 16'h0085);

    chk("pmem_exclusive", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/l1_dcache.md
# l1_dcache

Direct-mapped, write-back, write-allocate L1 cache that serves as the responder on the CPU-side word memory interface driven by the pipeline datapath (D-side, also usable as I-side with `mem_write` tied low). It answers `mem_read`/`mem_write` requests with a single-cycle `mem_resp` pulse and is itself an initiator on a 128-bit line-granular physical-memory interface for fills and evictions. Geometry is fixed at 8 lines of 16 bytes.

## Interface
- No parameters. Geometry is fixed: 8 sets, 16-byte lines, 16-bit address.
- Address split: tag = `mem_address[15:7]` (9b), index = `[6:4]`, word = `[3:1]`; `[0]` ignored.
- Clocking, fixed: reset `reset`, asynchronous, active-high; clock `clk`.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous active-high reset
- `mem_address`  in  16  CPU byte address, held stable until `mem_resp`
- `mem_read`  in  1  CPU read request, level
- `mem_write`  in  1  CPU write request, level
- `mem_byte_enable`  in  2  write mask; [1] = high byte, [0] = low byte
- `mem_wdata`  in  16  CPU write data
- `mem_rdata`  out  16  read data, valid in the `mem_resp` cycle
- `mem_resp`  out  1  registered one-cycle completion pulse
- `pmem_address`  out  16  line address, `[3:0]` = 0
- `pmem_read`  out  1  line fill request, level
- `pmem_write`  out  1  line writeback request, level
- `pmem_wdata`  out  128  evicted line; word k = bits `[16k+15:16k]`
- `pmem_rdata`  in  128  fill line, valid when `pmem_resp` is high
- `pmem_resp`  in  1  physical memory completion, one-cycle pulse

## Operation
- Arrays per set: `valid`, `dirty`, 9-bit `tag`, 128-bit `data`. Reset clears `valid` and `dirty`. Tag and data are not reset.
- Hit = `valid[index] && tag[index] == mem_address[15:7]`.
- **IDLE**:
  - No request: stay in IDLE.
  - Read hit: register the selected word into `mem_rdata`, go to RESP.
  - Write hit: merge `mem_wdata` into the selected word under `mem_byte_enable` at the clock edge, set `dirty`, go to RESP.
  - Miss with a dirty victim: go to WRITEBACK.
  - Miss with a clean or invalid victim: go to ALLOCATE.
  - `mem_read` and `mem_write` both high: the request is treated as a write.
- **WRITEBACK**:
  - Drive `pmem_write` = 1, `pmem_address` = {victim tag, index, 4'b0}, `pmem_wdata` = victim line.
  - On `pmem_resp`: clear `dirty`, go to ALLOCATE.
- **ALLOCATE**:
  - Drive `pmem_read` = 1, `pmem_address` = {`mem_address[15:4]`, 4'b0}.
  - On `pmem_resp`: write `pmem_rdata` into the line, set `valid`, clear `dirty`, load `tag`, go to IDLE.
  - IDLE then re-evaluates, and the request now hits.
- **RESP**:
  - `mem_resp` = 1 for exactly this cycle. No request is sampled.
  - Always returns to IDLE.
- `mem_resp` is a flop output and has no combinational path from the request inputs. This is required because the I-side requester derives `mem_read` from `~mem_resp`.
- A request withdrawn during a miss does not abort it: the fill completes, IDLE sees no request, and no `mem_resp` is issued.
- Byte enable affects writes only. Reads always return the full word.
- `mem_byte_enable` = 2'b00 on a write hit: data is unchanged, `dirty` is still set, `mem_resp` is still issued.

## Timing
- Reset values: state IDLE; `mem_resp` 0, `mem_rdata` 0, `pmem_read` 0, `pmem_write` 0, `pmem_address` 0, `pmem_wdata` don't-care.
- Reset asserted mid-transaction drops `pmem_read`/`pmem_write` immediately. The in-flight fill or writeback is abandoned and the line stays invalid.
- Hit latency: request visible in cycle N, `mem_resp` in cycle N+1. Back-to-back hits take 2 cycles each.
- Clean miss: request in N, `pmem_read` from N+1 until the `pmem_resp` cycle M, back to IDLE at M+1, `mem_resp` at M+2.
- Dirty miss: adds the WRITEBACK duration before ALLOCATE.
- `pmem_*` outputs are decoded from state and stay stable while waiting for `pmem_resp`. `pmem_read` and `pmem_write` are never high together.
- `pmem_resp` arriving outside WRITEBACK or ALLOCATE is ignored.

## Test plan
- **Cold read miss:** after reset, read `0x1234` while pmem returns a line with word 2 = `0xBEEF` after 5 cycles.
  - One `pmem_read` at `pmem_address` `0x1230`.
  - `mem_resp` with `mem_rdata` = `0xBEEF` two cycles after `pmem_resp`.
- **Read hit:** re-read `0x1234`.
  - No pmem activity, `mem_resp` the next cycle with `0xBEEF`.
  - Hold `mem_read` high for 6 cycles and check that `mem_resp` pulses every 2 cycles.
- **Byte-masked write hit:** write `0xAA55` to `0x1234` with enable 2'b10, then read `0x1234`.
  - The read returns `0xAAEF`.
  - The write asserts no `pmem_write`.
- **Dirty conflict miss:** read `0x1A34` (same index, tag differs).
  - `pmem_write` at `0x1230` with word 2 of `pmem_wdata` = `0xAAEF`.
  - Then `pmem_read` at `0x1A30`, then `mem_resp`.
  - A later re-read of `0x1234` causes a clean miss with no writeback.
- **Reset during ALLOCATE:** assert `reset` while `pmem_read` is high.
  - `pmem_read` falls in the same cycle and `mem_resp` stays 0.
  - After release, a read of the same address misses again.
- **I-side style request:** drive `mem_read` = ~`mem_resp` continuously over sequential addresses `0x0000`–`0x001E`.
  - No combinational loop.
  - Exactly 2 fills, and every returned word is correct.
